// File: rtl/trap_sequencer_if.sv
// Core <-> trap sequencer bus: boundary request inputs, CSR values, and the
// trap/return strobes and CSR update values sent back.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            instr_valid_i;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] bad_addr_i;
    logic [5:0]      exc_req_i;
    logic            mret_i;
    logic            mtime_exc_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;

    logic            jumpingToMtvec_o;
    logic [XLEN-1:0] excCause_o;
    logic [XLEN-1:0] trapInfo_o;
    logic [XLEN-1:0] trapPc_o;
    logic            stall_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            mret_o;
    logic [31:0]     trap_count_o;

    modport slave (
        input  instr_valid_i, pc_i, instr_i, bad_addr_i, exc_req_i, mret_i,
               mtime_exc_i, mtvec_i, mepc_i,
        output jumpingToMtvec_o, excCause_o, trapInfo_o, trapPc_o, stall_o,
               redirect_o, redirect_pc_o, mret_o, trap_count_o
    );

    modport master (
        output instr_valid_i, pc_i, instr_i, bad_addr_i, exc_req_i, mret_i,
               mtime_exc_i, mtvec_i, mepc_i,
        input  jumpingToMtvec_o, excCause_o, trapInfo_o, trapPc_o, stall_o,
               redirect_o, redirect_pc_o, mret_o, trap_count_o
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: prioritises boundary requests,
// captures mcause/mtval/mepc, strobes the CSR unit and redirects the PC.
module trap_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] INT_CAUSE = XLEN'(32'h8000_0007)
) (
    input logic            clk,
    input logic            rst,
    trap_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENTRY, VECTOR, RETURN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] info_q, info_d;
    logic [XLEN-1:0] tpc_q, tpc_d;
    logic [31:0]     trap_cnt_q, trap_cnt_d;

    logic            jump;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            mret_strobe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cause_q    <= '0;
            info_q     <= '0;
            tpc_q      <= '0;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            info_q     <= info_d;
            tpc_q      <= tpc_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        info_d      = info_q;
        tpc_d       = tpc_q;
        trap_cnt_d  = trap_cnt_q;
        jump        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mret_strobe = 1'b0;

        case (state_q)
            IDLE: begin
                // Requests are only looked at on a commit boundary; a losing
                // request is simply dropped.
                if (bus.instr_valid_i) begin
                    if ((|bus.exc_req_i) || bus.mtime_exc_i) begin
                        state_d = ENTRY;
                        tpc_d   = bus.pc_i;
                        if (bus.exc_req_i[0]) begin
                            cause_d = XLEN'(0);
                            info_d  = bus.bad_addr_i;
                        end else if (bus.exc_req_i[1]) begin
                            cause_d = XLEN'(2);
                            info_d  = XLEN'(bus.instr_i);
                        end else if (bus.exc_req_i[2]) begin
                            cause_d = XLEN'(3);
                            info_d  = bus.pc_i;
                        end else if (bus.exc_req_i[3]) begin
                            cause_d = XLEN'(11);
                            info_d  = '0;
                        end else if (bus.exc_req_i[4]) begin
                            cause_d = XLEN'(4);
                            info_d  = bus.bad_addr_i;
                        end else if (bus.exc_req_i[5]) begin
                            cause_d = XLEN'(6);
                            info_d  = bus.bad_addr_i;
                        end else begin
                            cause_d = INT_CAUSE;
                            info_d  = '0;
                        end
                    end else if (bus.mret_i) begin
                        state_d = RETURN;
                    end
                end
            end
            ENTRY: begin
                jump       = 1'b1;
                trap_cnt_d = trap_cnt_q + 32'd1;
                state_d    = VECTOR;
            end
            VECTOR: begin
                redirect    = 1'b1;
                redirect_pc = bus.mtvec_i & ~XLEN'(3);
                state_d     = IDLE;
            end
            RETURN: begin
                mret_strobe = 1'b1;
                redirect    = 1'b1;
                redirect_pc = bus.mepc_i;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.jumpingToMtvec_o = jump;
    assign bus.excCause_o       = cause_q;
    assign bus.trapInfo_o       = info_q;
    assign bus.trapPc_o         = tpc_q;
    assign bus.stall_o          = (state_q != IDLE);
    assign bus.redirect_o       = redirect;
    assign bus.redirect_pc_o    = redirect_pc;
    assign bus.mret_o           = mret_strobe;
    assign bus.trap_count_o     = trap_cnt_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: vector table of boundary requests plus
// hand-written interrupt-deferral, mid-trap reset and counter-wrap sequences.
module tb_trap_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_count;

    trap_sequencer_if #(.XLEN(32)) bus ();

    trap_sequencer #(
        .XLEN     (32),
        .INT_CAUSE(32'h8000_0007)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  exc;
        logic        mret;
        logic        mtime;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] bad;
        int          kind;   // 0 no action, 1 trap, 2 mret
        logic [31:0] cause;
        logic [31:0] info;
    } vec_t;

    localparam logic [31:0] MTVEC     = 32'h0000_1003;
    localparam logic [31:0] MTVEC_TGT = 32'h0000_1000;
    localparam logic [31:0] MEPC      = 32'h0000_0404;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.instr_valid_i = 1'b0;
        bus.exc_req_i     = '0;
        bus.mret_i        = 1'b0;
        bus.mtime_exc_i   = 1'b0;
        bus.pc_i          = '0;
        bus.instr_i       = '0;
        bus.bad_addr_i    = '0;
    endtask

    // Called at a falling edge: presents one boundary for one cycle and
    // follows the resulting sequence to its end.
    task automatic run_vec(input vec_t v);
        bus.instr_valid_i = 1'b1;
        bus.exc_req_i     = v.exc;
        bus.mret_i        = v.mret;
        bus.mtime_exc_i   = v.mtime;
        bus.pc_i          = v.pc;
        bus.instr_i       = v.instr;
        bus.bad_addr_i    = v.bad;
        @(negedge clk);
        clear_inputs();
        if (v.kind == 1) begin
            chk({v.name, ".n1.jump"},   32'(bus.jumpingToMtvec_o), 32'd1);
            chk({v.name, ".n1.mret"},   32'(bus.mret_o), 32'd0);
            chk({v.name, ".n1.stall"},  32'(bus.stall_o), 32'd1);
            chk({v.name, ".n1.redir"},  32'(bus.redirect_o), 32'd0);
            chk({v.name, ".n1.cause"},  bus.excCause_o, v.cause);
            chk({v.name, ".n1.info"},   bus.trapInfo_o, v.info);
            chk({v.name, ".n1.tpc"},    bus.trapPc_o, v.pc);
            @(negedge clk);
            exp_count = exp_count + 32'd1;
            chk({v.name, ".n2.redir"},  32'(bus.redirect_o), 32'd1);
            chk({v.name, ".n2.rpc"},    bus.redirect_pc_o, MTVEC_TGT);
            chk({v.name, ".n2.jump"},   32'(bus.jumpingToMtvec_o), 32'd0);
            chk({v.name, ".n2.stall"},  32'(bus.stall_o), 32'd1);
            chk({v.name, ".n2.cause"},  bus.excCause_o, v.cause);
            chk({v.name, ".n2.info"},   bus.trapInfo_o, v.info);
            @(negedge clk);
            chk({v.name, ".n3.stall"},  32'(bus.stall_o), 32'd0);
            chk({v.name, ".n3.redir"},  32'(bus.redirect_o), 32'd0);
            chk({v.name, ".n3.count"},  bus.trap_count_o, exp_count);
        end else if (v.kind == 2) begin
            chk({v.name, ".n1.mret"},   32'(bus.mret_o), 32'd1);
            chk({v.name, ".n1.redir"},  32'(bus.redirect_o), 32'd1);
            chk({v.name, ".n1.rpc"},    bus.redirect_pc_o, MEPC);
            chk({v.name, ".n1.jump"},   32'(bus.jumpingToMtvec_o), 32'd0);
            chk({v.name, ".n1.stall"},  32'(bus.stall_o), 32'd1);
            @(negedge clk);
            chk({v.name, ".n2.stall"},  32'(bus.stall_o), 32'd0);
            chk({v.name, ".n2.mret"},   32'(bus.mret_o), 32'd0);
            chk({v.name, ".n2.redir"},  32'(bus.redirect_o), 32'd0);
            chk({v.name, ".n2.count"},  bus.trap_count_o, exp_count);
        end else begin
            chk({v.name, ".stall"},     32'(bus.stall_o), 32'd0);
            chk({v.name, ".jump"},      32'(bus.jumpingToMtvec_o), 32'd0);
            chk({v.name, ".redir"},     32'(bus.redirect_o), 32'd0);
            chk({v.name, ".count"},     bus.trap_count_o, exp_count);
        end
    endtask

    initial begin
        vec_t v;
        n_tests   = 0;
        n_fail    = 0;
        exp_count = '0;

        //                name      exc        mret  mtime pc            instr         bad           kind cause          info
        vecs[0] = '{"illegal",  6'b000010, 1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_DEAD, 1, 32'd2,         32'hFFFF_FFFF};
        vecs[1] = '{"fetchmis", 6'b111111, 1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0000_0123, 1, 32'd0,         32'h0000_0123};
        vecs[2] = '{"ebrk_ecl", 6'b001100, 1'b0, 1'b1, 32'h0000_0300, 32'h0010_0073, 32'h0000_0000, 1, 32'd3,         32'h0000_0300};
        vecs[3] = '{"ecall",    6'b001000, 1'b1, 1'b1, 32'h0000_0308, 32'h0000_0073, 32'h0000_0999, 1, 32'd11,        32'h0000_0000};
        vecs[4] = '{"loadmis",  6'b110000, 1'b0, 1'b1, 32'h0000_0310, 32'h0000_0003, 32'h0000_0055, 1, 32'd4,         32'h0000_0055};
        vecs[5] = '{"storemis", 6'b100000, 1'b1, 1'b0, 32'h0000_0314, 32'h0000_0023, 32'h0000_0077, 1, 32'd6,         32'h0000_0077};
        vecs[6] = '{"timer",    6'b000000, 1'b1, 1'b1, 32'h0000_0240, 32'h0000_0013, 32'h0000_0011, 1, 32'h8000_0007, 32'h0000_0000};
        vecs[7] = '{"mret",     6'b000000, 1'b1, 1'b0, 32'h0000_0500, 32'h3020_0073, 32'h0000_0000, 2, 32'd0,         32'd0};
        vecs[8] = '{"noreq",    6'b000000, 1'b0, 1'b0, 32'h0000_0504, 32'h0000_0013, 32'h0000_0000, 0, 32'd0,         32'd0};
        vecs[9] = '{"ill_lo",   6'b000010, 1'b0, 1'b0, 32'h0000_0508, 32'h0000_0001, 32'h0000_0000, 1, 32'd2,         32'h0000_0001};

        rst         = 1'b0;
        bus.mtvec_i = MTVEC;
        bus.mepc_i  = MEPC;
        clear_inputs();
        repeat (2) @(negedge clk);

        chk("rst.stall", 32'(bus.stall_o), 32'd0);
        chk("rst.jump",  32'(bus.jumpingToMtvec_o), 32'd0);
        chk("rst.redir", 32'(bus.redirect_o), 32'd0);
        chk("rst.rpc",   bus.redirect_pc_o, 32'd0);
        chk("rst.mret",  32'(bus.mret_o), 32'd0);
        chk("rst.cause", bus.excCause_o, 32'd0);
        chk("rst.info",  bus.trapInfo_o, 32'd0);
        chk("rst.tpc",   bus.trapPc_o, 32'd0);
        chk("rst.count", bus.trap_count_o, 32'd0);

        // First vector is presented in the same cycle reset releases.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Pending timer with no boundary: nothing happens until instr_valid_i.
        bus.mtime_exc_i = 1'b1;
        bus.pc_i        = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("irqwait.stall", 32'(bus.stall_o), 32'd0);
            chk("irqwait.jump",  32'(bus.jumpingToMtvec_o), 32'd0);
        end
        v = '{"irq_boundary", 6'b000000, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0013, 32'h0000_0000, 1, 32'h8000_0007, 32'h0000_0000};
        run_vec(v);

        // Reset asserted during ENTRY.
        bus.instr_valid_i = 1'b1;
        bus.exc_req_i     = 6'b000010;
        bus.pc_i          = 32'h0000_0600;
        bus.instr_i       = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        chk("midrst.entry.jump", 32'(bus.jumpingToMtvec_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_count = '0;
        chk("midrst.jump",  32'(bus.jumpingToMtvec_o), 32'd0);
        chk("midrst.stall", 32'(bus.stall_o), 32'd0);
        chk("midrst.cause", bus.excCause_o, 32'd0);
        chk("midrst.info",  bus.trapInfo_o, 32'd0);
        chk("midrst.tpc",   bus.trapPc_o, 32'd0);
        chk("midrst.count", bus.trap_count_o, 32'd0);
        @(negedge clk);
        chk("midrst.hold.redir", 32'(bus.redirect_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.rel.redir", 32'(bus.redirect_o), 32'd0);
        chk("midrst.rel.stall", 32'(bus.stall_o), 32'd0);
        chk("midrst.rel.jump",  32'(bus.jumpingToMtvec_o), 32'd0);
        v = '{"postrst", 6'b000100, 1'b0, 1'b0, 32'h0000_0700, 32'h0010_0073, 32'h0000_0000, 1, 32'd3, 32'h0000_0700};
        run_vec(v);

        // Counter wrap from all-ones.
        force dut.trap_cnt_q = 32'hFFFF_FFFF;
        #1;
        chk("wrap.preload", bus.trap_count_o, 32'hFFFF_FFFF);
        release dut.trap_cnt_q;
        exp_count = 32'hFFFF_FFFF;
        @(negedge clk);
        v = '{"wrap", 6'b001000, 1'b0, 1'b0, 32'h0000_0800, 32'h0000_0073, 32'h0000_0000, 1, 32'd11, 32'h0000_0000};
        run_vec(v);
        chk("wrap.zero", bus.trap_count_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
